output_display_scan: RTL and testbench

// - Parametrised successor to the computer's 8-bit output register. Latches a DATA_W-bit bus

---
 rtl/display_pkg.sv | 49 ++++
 rtl/bcd_dabble_seq.sv | 67 ++++++
 rtl/output_display_scan.sv | 132 +++++++++++++
 tb/tb_output_display_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the output display path.
//   SEG_0..SEG_9, SEG_BLANK, SEG_MINUS : 7-segment patterns, bit order {a,b,c,d,e,f,g}, 1 = lit
//   bcd_to_seg(nibble)                : BCD digit to segment pattern (anything above 9 is blank)
//   digits_for_width(width, is_signed): decimal digits needed to show 2^width-1, plus one for a sign
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h01;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic int digits_for_width(input int width, input bit is_signed);
        longint v;
        int     n;
        v = (longint'(1) << width) - 1;
        n = 0;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        if (n == 0) n = 1;
        return n + (is_signed ? 1 : 0);
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
//   clk   : clock, rising edge
//   clear : synchronous active-high reset, aborts a conversion in flight
//   start : load bin and perform the first shift on this edge (overrides a running conversion)
//   bin   : binary value to convert
//   busy  : conversion has started and not yet finished
//   done  : combinational, high in the cycle whose closing edge performs the final shift
//   bcd   : BCD result of that final shift, valid while done is high
module bcd_dabble_seq
    import display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [SR_W-1:0]  sr_q, sr_d, src, adj;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // On start the BCD part is all zero, so the add-3 step is a no-op and the
    // first shift can be taken straight from the freshly loaded value.
    always_comb begin
        // NOTE: every variable gets a default before the conditional updates, so no latch is inferred.
        src = start ? {{BCD_W{1'b0}}, bin} : sr_q;
        adj = src;
        for (int i = 0; i < DIGITS; i++) begin
            if (src[DATA_W+4*i +: 4] > 4'd4)
                adj[DATA_W+4*i +: 4] = src[DATA_W+4*i +: 4] + 4'd3;
        end
        sr_d = adj << 1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (clear) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            sr_q   <= sr_d;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && !start && (cnt_q == LAST);
    assign bcd  = sr_d[SR_W-1 -: BCD_W];

endmodule

// File: rtl/output_display_scan.sv
// Output register with decimal, multiplexed 7-segment display.
//   clk        : clock, all state on rising edge
//   clear      : synchronous active-high reset
//   bus        : shared data bus
//   input_en   : capture bus into the data register this edge
//   busy       : BCD conversion pending or in progress
//   display    : segments {a,b,c,d,e,f,g}, 1 = lit (registered)
//   display_en : active-low one-hot digit enables, bit 0 = least significant digit (registered)
module output_display_scan
    import display_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000,
    parameter int SIGNED   = 0,
    parameter int LZB      = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus,
    input  logic              input_en,
    output logic              busy,
    output logic [6:0]        display,
    output logic [DIGITS-1:0] display_en
);

    if (DATA_W < 2 || DATA_W > 16) begin : g_bad_width
        $error("output_display_scan: DATA_W must be 2..16");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
        $error("output_display_scan: SCAN_DIV must be >= 1");
    end
    if (DIGITS < digits_for_width(DATA_W, SIGNED != 0)) begin : g_bad_digits
        $error("output_display_scan: DIGITS too small for DATA_W/SIGNED");
    end

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [DATA_W-1:0]   data_q;
    logic                start_q;
    logic [4*DIGITS-1:0] digits_q;
    logic                neg_q;
    logic [CNT_W-1:0]    scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          display_q, seg_d;
    logic [DIGITS-1:0]   display_en_q, en_d;

    logic                is_neg;
    logic [DATA_W-1:0]   mag;
    logic                conv_busy, conv_done;
    logic [4*DIGITS-1:0] conv_bcd;

    // The most negative value negates to itself, which read unsigned is exactly its magnitude.
    assign is_neg = (SIGNED != 0) && data_q[DATA_W-1];
    assign mag    = is_neg ? -data_q : data_q;

    bcd_dabble_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .clear (clear),
        .start (start_q),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Scan divider and digit index.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == CNT_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Segment pattern for the slot that becomes active on the next edge.
    always_comb begin
        int         msd;
        int         sign_pos;
        logic [3:0] nib;
        msd = 0;
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] != 4'd0) msd = i;
            if (int'(idx_d) == i) nib = digits_q[4*i +: 4];
            en_d[i] = (int'(idx_d) != i);
        end
        sign_pos = (LZB != 0) ? msd + 1 : DIGITS - 1;
        seg_d    = bcd_to_seg(nib);
        // Digit 0 is never above msd, so it is never blanked.
        if (LZB != 0 && int'(idx_d) > msd) seg_d = SEG_BLANK;
        if (SIGNED != 0 && int'(idx_d) == sign_pos) seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            data_q       <= '0;
            start_q      <= 1'b0;
            digits_q     <= '0;
            neg_q        <= 1'b0;
            scan_q       <= '0;
            idx_q        <= '0;
            display_q    <= SEG_0;
            display_en_q <= ~DIGITS'(1);
        end else begin
            start_q <= input_en;
            if (input_en) data_q <= bus;
            // Shadow digits only move on completion; partial results stay hidden.
            if (conv_done) begin
                digits_q <= conv_bcd;
                neg_q    <= is_neg;
            end
            scan_q       <= scan_d;
            idx_q        <= idx_d;
            display_q    <= seg_d;
            display_en_q <= en_d;
        end
    end

    // A load pending for the converter counts as busy, so busy rises right after the capture edge.
    assign busy       = start_q | conv_busy;
    assign display    = display_q;
    assign display_en = display_en_q;

endmodule

// File: tb/tb_output_display_scan.sv
module tb_output_display_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;
    logic [15:0] bus_v [5];
    logic [4:0]  en_v;
    logic [4:0]  busy_v;
    logic [6:0]  disp  [5];
    logic [3:0]  den   [5];
    logic [2:0]  de0, de2;
    logic [3:0]  de1, de3, de4;

    // Unused enable bits padded with 1 so every instance compares as 4 bits.
    assign den[0] = {1'b1, de0};
    assign den[1] = de1;
    assign den[2] = {1'b1, de2};
    assign den[3] = de3;
    assign den[4] = de4;

    output_display_scan #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(2), .SIGNED(0), .LZB(1)) u0 (
        .clk(clk), .clear(clear), .bus(bus_v[0][7:0]), .input_en(en_v[0]),
        .busy(busy_v[0]), .display(disp[0]), .display_en(de0));
    output_display_scan #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(2), .SIGNED(1), .LZB(1)) u1 (
        .clk(clk), .clear(clear), .bus(bus_v[1][7:0]), .input_en(en_v[1]),
        .busy(busy_v[1]), .display(disp[1]), .display_en(de1));
    output_display_scan #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(2), .SIGNED(0), .LZB(0)) u2 (
        .clk(clk), .clear(clear), .bus(bus_v[2][7:0]), .input_en(en_v[2]),
        .busy(busy_v[2]), .display(disp[2]), .display_en(de2));
    output_display_scan #(.DATA_W(12), .DIGITS(4), .SCAN_DIV(5), .SIGNED(0), .LZB(1)) u3 (
        .clk(clk), .clear(clear), .bus(bus_v[3][11:0]), .input_en(en_v[3]),
        .busy(busy_v[3]), .display(disp[3]), .display_en(de3));
    output_display_scan #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(2), .SIGNED(1), .LZB(0)) u4 (
        .clk(clk), .clear(clear), .bus(bus_v[4][7:0]), .input_en(en_v[4]),
        .busy(busy_v[4]), .display(disp[4]), .display_en(de4));

    int w_of  [5] = '{8, 8, 8, 12, 8};
    int nd_of [5] = '{3, 4, 3, 4, 4};
    int sg_of [5] = '{0, 1, 0, 0, 1};
    int lz_of [5] = '{1, 1, 0, 1, 0};

    logic [6:0] lut [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int n_tests = 0;
    int n_fail  = 0;
    int shown [5];
    bit watch7 = 1'b0;
    bit saw7   = 1'b0;

    always @(negedge clk) if (watch7 && disp[0] === 7'h70) saw7 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected slot patterns from plain decimal arithmetic.
    function automatic logic [3:0][6:0] model_segs(int val, int w, int nd, int sg, int lz);
        logic [3:0][6:0] r;
        int d [4];
        int mag, msd, pos;
        bit neg;
        neg = (sg != 0) && (((val >> (w - 1)) & 1) == 1);
        mag = neg ? (1 << w) - val : val;
        for (int i = 0; i < 4; i++) begin
            d[i] = mag % 10;
            mag  = mag / 10;
        end
        msd = 0;
        for (int i = 0; i < nd; i++) if (d[i] != 0) msd = i;
        r = '0;
        for (int i = 0; i < nd; i++) r[i] = (lz != 0 && i > msd) ? 7'h00 : lut[d[i]];
        if (sg != 0) begin
            pos = (lz != 0) ? msd + 1 : nd - 1;
            r[pos] = neg ? 7'h01 : 7'h00;
        end
        return r;
    endfunction

    task automatic load(input int k, input int v);
        @(negedge clk);
        bus_v[k] = 16'(v);
        en_v[k]  = 1'b1;
        @(negedge clk);
        en_v[k]  = 1'b0;
    endtask

    task automatic count_busy(input int k, output int n);
        n = 0;
        while (busy_v[k] && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int k);
        for (int t = 0; t < 100 && busy_v[k]; t++) @(negedge clk);
        if (busy_v[k]) check($sformatf("u%0d idle timeout", k), 1, 0);
    endtask

    task automatic capture(input int k, output logic [3:0][6:0] got);
        logic [3:0] pat;
        bit found;
        got = '0;
        for (int j = 0; j < nd_of[k]; j++) begin
            pat   = ~(4'b0001 << j);
            found = 1'b0;
            for (int t = 0; t < 80 && !found; t++) begin
                @(negedge clk);
                if (den[k] === pat) begin
                    got[j] = disp[k];
                    found  = 1'b1;
                end
            end
            if (!found) check($sformatf("u%0d slot%0d timeout", k, j), 1, 0);
        end
    endtask

    task automatic verify(input int k, input int v, input string tag);
        logic [3:0][6:0] got, exp;
        exp = model_segs(v, w_of[k], nd_of[k], sg_of[k], lz_of[k]);
        capture(k, got);
        for (int j = 0; j < nd_of[k]; j++)
            check($sformatf("%s u%0d v=%0d digit%0d", tag, k, v, j), got[j], exp[j]);
    endtask

    task automatic run_value(input int k, input int v, input string tag);
        int n;
        load(k, v);
        count_busy(k, n);
        check($sformatf("%s u%0d busy cycles", tag, k), n, w_of[k]);
        wait_idle(k);
        repeat (45) @(negedge clk);
        shown[k] = v;
        verify(k, v, tag);
    endtask

    task automatic slot_len(input int k, input logic [3:0] pat, output int n);
        n = 0;
        for (int t = 0; t < 80 && den[k] === pat; t++) @(negedge clk);
        for (int t = 0; t < 80 && den[k] !== pat; t++) @(negedge clk);
        while (den[k] === pat && n < 80) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, a, b, r;
        bit held;
        clear = 1'b1;
        en_v  = '0;
        for (int k = 0; k < 5; k++) begin
            bus_v[k] = '0;
            shown[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset u0 display_en", den[0], 4'b1110);
        check("reset u0 display", disp[0], 7'h7E);
        check("reset u0 busy", busy_v[0], 0);
        check("reset u3 display_en", den[3], 4'b1110);
        clear = 1'b0;

        verify(0, 0, "idle");
        slot_len(0, 4'b1101, n);
        check("u0 slot length", n, 2);
        slot_len(3, 4'b1011, n);
        check("u3 slot length", n, 5);

        run_value(0, 255, "dir");

        // Restart two cycles after the first load; 7 must never be shown.
        saw7   = 1'b0;
        watch7 = 1'b1;
        load(0, 7);
        load(0, 42);
        count_busy(0, n);
        check("restart u0 busy cycles", n, 8);
        wait_idle(0);
        repeat (45) @(negedge clk);
        shown[0] = 42;
        verify(0, 42, "restart");
        watch7 = 1'b0;
        check("restart 7 never shown", saw7, 0);

        run_value(1, 8'h80, "dir");
        run_value(1, 8'hFF, "dir");
        run_value(4, 8'h80, "dir");
        run_value(4, 5, "dir");
        run_value(2, 5, "dir");
        run_value(3, 4095, "dir");

        // Clear during a conversion.
        load(2, 123);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear u2 busy", busy_v[2], 0);
        check("clear u2 display_en", den[2], 4'b1110);
        check("clear u2 display", disp[2], 7'h7E);
        for (int k = 0; k < 5; k++) shown[k] = 0;
        repeat (45) @(negedge clk);
        verify(2, 0, "after_clear");
        verify(0, 0, "after_clear");

        // Randomized loads and restarts on every configuration.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                a = $urandom_range((1 << w_of[k]) - 1, 0);
                run_value(k, a, "rand");
            end
            a = $urandom_range((1 << w_of[k]) - 1, 0);
            b = $urandom_range((1 << w_of[k]) - 1, 0);
            r = $urandom_range(w_of[k] - 2, 0);
            load(k, a);
            repeat (r) @(negedge clk);
            run_value(k, b, "rand_restart");
        end

        // input_en held every cycle: busy stays up, old digits stay shown.
        a = $urandom_range(255, 0);
        @(negedge clk);
        bus_v[0] = 16'(a);
        en_v[0]  = 1'b1;
        held     = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!busy_v[0]) held = 1'b0;
        end
        check("hold u0 busy stays high", held, 1);
        verify(0, shown[0], "hold_old");
        en_v[0] = 1'b0;
        wait_idle(0);
        repeat (45) @(negedge clk);
        shown[0] = a;
        verify(0, a, "hold_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
